// File: rtl/bus_sched_pkg.sv
// Shared definitions for the bus round-robin scheduler.
//   sched_state_e : scheduler FSM states (IDLE -> GRANT -> PUSH -> IDLE)
//   ID_W          : width of the destination ID field at the top of each packet
//   rr_next()     : rotating-priority pick. Returns the first pending index after
//                   'last', wrapping modulo n. If nothing is pending it returns 'last'.
package bus_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    PUSH  = 2'd2
  } sched_state_e;

  localparam int ID_W = 8;

  // Upper bound on the terminal count supported by rr_next
  localparam int MAX_DRVRS = 64;
  localparam int MAX_IDX_W = 6;

  // The scan runs from the farthest candidate to the nearest one. The nearest
  // pending source therefore overwrites every other pick, which avoids an early
  // exit. Loop bounds are constant; n is a parameter at every call site.
  function automatic int rr_next(input logic [MAX_DRVRS-1:0] pndng,
                                 input int last,
                                 input int n);
    int result;
    int cand;
    result = last;
    for (int k = MAX_DRVRS; k >= 1; k--) begin
      if (k <= n) begin
        cand = (last + k) % n;
        if (pndng[cand[MAX_IDX_W-1:0]]) begin
          result = cand;
        end
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/bus_rr_scheduler_rr_arbiter.sv
// rr_arbiter: combinational rotating-priority picker.
//   pndng [drvrs]         : request vector, one bit per source
//   last  [$clog2(drvrs)] : most recently served source (lowest priority now)
//   idx   [$clog2(drvrs)] : chosen source, meaningful only when valid=1
//   valid                 : at least one request present
module rr_arbiter
  import bus_sched_pkg::*;
#(
  parameter int drvrs = 4
) (
  input  logic [drvrs-1:0]         pndng,
  input  logic [$clog2(drvrs)-1:0] last,
  output logic [$clog2(drvrs)-1:0] idx,
  output logic                     valid
);

  localparam int IDX_W = $clog2(drvrs);

  logic [MAX_DRVRS-1:0] pnd_ext;

  assign pnd_ext = MAX_DRVRS'(pndng);
  assign idx     = IDX_W'(rr_next(pnd_ext, int'(last), drvrs));
  assign valid   = |pndng;

endmodule

// File: rtl/bus_rr_scheduler.sv
// bus_rr_scheduler: round-robin scheduler for the shared bus between terminal FIFOs.
// Each transaction picks one pending source, pops its head packet, and then
// delivers that packet to the terminal(s) named in its top ID_W bits.
//   clk            : bus clock, rising edge
//   reset          : synchronous, active-low
//   pndng  [drvrs] : FIFO i holds a packet
//   D_pop  [drvrs] : head packet of FIFO i
//   pop    [drvrs] : one-cycle dequeue pulse for the granted FIFO
//   push   [drvrs] : one-cycle delivery strobe per destination terminal
//   D_push [drvrs] : delivered packet; every lane carries the same value
//   busy           : high during GRANT and PUSH
//   grant          : index of the source currently or last granted
//   drop_cnt[16]   : saturating count of packets with an invalid ID
//                    (present only when DROP_STATS_EN is defined)
// Optional feature macro: DROP_STATS_EN
module bus_rr_scheduler
  import bus_sched_pkg::*;
#(
  parameter int              drvrs     = 4,
  parameter int              pckg_sz   = 16,
  parameter logic [ID_W-1:0] broadcast = 8'hFF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [drvrs-1:0]         pndng,
  input  logic [pckg_sz-1:0]       D_pop [drvrs],
  output logic [drvrs-1:0]         pop,
  output logic [drvrs-1:0]         push,
  output logic [pckg_sz-1:0]       D_push [drvrs],
  output logic                     busy,
`ifdef DROP_STATS_EN
  output logic [15:0]              drop_cnt,
`endif
  output logic [$clog2(drvrs)-1:0] grant
);

  localparam int GW = $clog2(drvrs);
  localparam logic [drvrs-1:0] ONE_HOT0 = {{(drvrs-1){1'b0}}, 1'b1};

  sched_state_e      state_reg, state_next;
  logic [GW-1:0]     last_reg, last_next;
  logic [GW-1:0]     grant_reg, grant_next;
  logic [pckg_sz-1:0] pkt_reg, pkt_next;
  logic [drvrs-1:0]  pop_vec, push_vec;

  logic [GW-1:0]     arb_idx;
  logic              arb_valid;

  logic [ID_W-1:0]   pkt_id;
  logic              id_unicast;
  logic              id_bcast;

  rr_arbiter #(.drvrs(drvrs)) u_arb (
    .pndng (pndng),
    .last  (last_reg),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  // Destination decode. A numeric ID below drvrs wins over the broadcast code,
  // so a broadcast value that collides with a real terminal stays a unicast.
  assign pkt_id     = pkt_reg[pckg_sz-1 -: ID_W];
  assign id_unicast = int'(pkt_id) < drvrs;
  assign id_bcast   = (pkt_id == broadcast) && !id_unicast;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      last_reg  <= GW'(drvrs - 1);
      grant_reg <= '0;
      pkt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      last_reg  <= last_next;
      grant_reg <= grant_next;
      pkt_reg   <= pkt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    last_next  = last_reg;
    grant_next = grant_reg;
    pkt_next   = pkt_reg;
    pop_vec    = '0;
    push_vec   = '0;
    case (state_reg)
      IDLE: begin
        if (arb_valid) begin
          grant_next = arb_idx;
          last_next  = arb_idx;
          state_next = GRANT;
        end
      end
      GRANT: begin
        // The pop goes out even if pndng has dropped since the decision.
        pkt_next          = D_pop[grant_reg];
        pop_vec[grant_reg] = 1'b1;
        state_next        = PUSH;
      end
      PUSH: begin
        if (id_unicast) begin
          push_vec = ONE_HOT0 << pkt_id;
        end else if (id_bcast) begin
          push_vec = ~(ONE_HOT0 << grant_reg);
        end
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign pop   = pop_vec;
  assign push  = push_vec;
  assign busy  = (state_reg != IDLE);
  assign grant = grant_reg;

  // Every lane sees the same packet; push alone says which lanes take it.
  for (genvar gi = 0; gi < drvrs; gi++) begin : g_lane
    assign D_push[gi] = pkt_reg;
  end

`ifdef DROP_STATS_EN
  logic        drop_now;
  logic [15:0] drop_cnt_reg;

  assign drop_now = (state_reg == PUSH) && !id_unicast && !id_bcast;

  always_ff @(posedge clk) begin
    if (!reset) begin
      drop_cnt_reg <= '0;
    end else if (drop_now && (drop_cnt_reg != 16'hFFFF)) begin
      drop_cnt_reg <= drop_cnt_reg + 16'd1;
    end
  end

  assign drop_cnt = drop_cnt_reg;
`endif

endmodule
